// File: rtl/cpu_pkg.sv
// Shared types for the writeback/commit stage: memory-op encoding and the
// trace FSM states.
package cpu_pkg;

  localparam int MMOP_W = 4;

  typedef enum logic [MMOP_W-1:0] {
    MOP_NONE = 4'd0,
    LB       = 4'd1,
    LBU      = 4'd2,
    LH       = 4'd3,
    LHU      = 4'd4,
    LW       = 4'd5,
    LWL      = 4'd6,
    LWR      = 4'd7,
    SB       = 4'd8,
    SH       = 4'd9,
    SW       = 4'd10,
    SWL      = 4'd11,
    SWR      = 4'd12
  } mmop_e;

  typedef enum logic {
    S_RUN    = 1'b0,
    S_SECOND = 1'b1
  } wb_state_e;

  localparam logic [3:0] TRACE_WEN_ALL = 4'hF;

endpackage

// File: rtl/wb_load_align.sv
// Load-data extraction for one lane: byte/halfword pick with sign or zero
// extension, and the unaligned LWL/LWR merges against the old rt value.
// The merge patterns are defined for a 32-bit word, little-endian.
module wb_load_align
  import cpu_pkg::*;
#(
  parameter int DW = 32
) (
  input  mmop_e           memop,
  input  logic [1:0]      lo,
  input  logic [DW-1:0]   mem_rdata,
  input  logic [DW-1:0]   wdata,
  output logic [DW-1:0]   result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = mem_rdata[{lo, 3'b000} +: 8];
  assign half_sel = lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  // Select the final register value from the memop; non-loads pass wdata.
  always_comb begin
    result = wdata;
    case (memop)
      LB:  result = {{24{byte_sel[7]}}, byte_sel};
      LBU: result = {24'h0, byte_sel};
      LH:  result = {{16{half_sel[15]}}, half_sel};
      LHU: result = {16'h0, half_sel};
      LW:  result = mem_rdata;
      LWL: begin
        case (lo)
          2'd0:    result = {mem_rdata[7:0],  wdata[23:0]};
          2'd1:    result = {mem_rdata[15:0], wdata[15:0]};
          2'd2:    result = {mem_rdata[23:0], wdata[7:0]};
          default: result = mem_rdata;
        endcase
      end
      LWR: begin
        case (lo)
          2'd0:    result = mem_rdata;
          2'd1:    result = {wdata[31:24], mem_rdata[31:8]};
          2'd2:    result = {wdata[31:16], mem_rdata[31:16]};
          default: result = {wdata[31:8],  mem_rdata[31:24]};
        endcase
      end
      default: result = wdata;
    endcase
  end

endmodule

// File: rtl/wb_commit.sv
// Writeback/commit stage: MEM->WB register, load alignment per lane,
// regfile write ports and a debug trace port that serialises dual commits.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_RUN    | trace shows lowest committing lane; dual commit -> busy
// S_SECOND | trace shows latched lane-1 record; regfile writes blocked
module wb_commit
  import cpu_pkg::*;
#(
  parameter int LANES = 2,
  parameter int DW    = 32,
  parameter int RW    = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wb_stall_i,
  input  logic                    wb_flush_i,
  input  logic [LANES-1:0]        in_valid_i,
  input  logic [LANES*DW-1:0]     in_pc_i,
  input  logic [LANES*MMOP_W-1:0] in_memop_i,
  input  logic [LANES-1:0]        in_wren_i,
  input  logic [LANES*RW-1:0]     in_waddr_i,
  input  logic [LANES*DW-1:0]     in_wdata_i,
  input  logic [LANES*2-1:0]      in_maddr_lo_i,
  input  logic [LANES*DW-1:0]     mem_rdata_i,
  output logic                    wb_busy_o,
  output logic [LANES-1:0]        wb_wren_o,
  output logic [LANES*RW-1:0]     wb_waddr_o,
  output logic [LANES*DW-1:0]     wb_wdata_o,
  output logic [DW-1:0]           debug_wb_pc,
  output logic [3:0]              debug_wb_rf_wen,
  output logic [RW-1:0]           debug_wb_rf_wnum,
  output logic [DW-1:0]           debug_wb_rf_wdata
);

  logic [LANES-1:0]        valid_q, valid_d;
  logic [LANES*DW-1:0]     pc_q, pc_d;
  logic [LANES*MMOP_W-1:0] memop_q, memop_d;
  logic [LANES-1:0]        wren_q, wren_d;
  logic [LANES*RW-1:0]     waddr_q, waddr_d;
  logic [LANES*DW-1:0]     wdata_q, wdata_d;
  logic [LANES*2-1:0]      lo_q, lo_d;

  logic [LANES*DW-1:0]     result;
  logic [LANES-1:0]        commit;
  logic [LANES-1:0]        wen_raw;
  logic                    hold;

  assign hold = wb_stall_i | wb_busy_o;

  // Stage register next value: flush beats hold beats load.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    memop_d = memop_q;
    wren_d  = wren_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    lo_d    = lo_q;
    if (wb_flush_i) begin
      valid_d = '0;
    end else if (!hold) begin
      valid_d = in_valid_i;
      pc_d    = in_pc_i;
      memop_d = in_memop_i;
      wren_d  = in_wren_i;
      waddr_d = in_waddr_i;
      wdata_d = in_wdata_i;
      lo_d    = in_maddr_lo_i;
    end
  end

  // Stage register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      pc_q    <= '0;
      memop_q <= '0;
      wren_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      memop_q <= memop_d;
      wren_q  <= wren_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      lo_q    <= lo_d;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    wb_load_align #(.DW(DW)) u_align (
      .memop     (mmop_e'(memop_q[i*MMOP_W +: MMOP_W])),
      .lo        (lo_q[2*i +: 2]),
      .mem_rdata (mem_rdata_i[i*DW +: DW]),
      .wdata     (wdata_q[i*DW +: DW]),
      .result    (result[i*DW +: DW])
    );
    // $0 still counts as a commit for the trace, but never writes the regfile.
    assign commit[i]  = valid_q[i] & wren_q[i];
    assign wen_raw[i] = commit[i] & (waddr_q[i*RW +: RW] != '0);
  end

  assign wb_waddr_o = waddr_q;
  assign wb_wdata_o = result;

  if (LANES == 2) begin : g_dual
    wb_state_e       state_q, state_d;
    logic [DW-1:0]   sh_pc_q, sh_pc_d;
    logic [RW-1:0]   sh_wnum_q, sh_wnum_d;
    logic [DW-1:0]   sh_wdata_q, sh_wdata_d;

    // Trace FSM, regfile enables and busy; lane-1 trace is parked in the
    // shadow while the stage is held for one extra cycle.
    always_comb begin
      state_d           = state_q;
      sh_pc_d           = sh_pc_q;
      sh_wnum_d         = sh_wnum_q;
      sh_wdata_d        = sh_wdata_q;
      wb_busy_o         = 1'b0;
      wb_wren_o         = '0;
      debug_wb_pc       = pc_q[DW-1:0];
      debug_wb_rf_wen   = 4'h0;
      debug_wb_rf_wnum  = '0;
      debug_wb_rf_wdata = '0;
      case (state_q)
        S_RUN: begin
          wb_wren_o = wen_raw;
          // Same destination: the younger lane's value must survive.
          if (wen_raw[0] && wen_raw[1] && (waddr_q[RW-1:0] == waddr_q[RW +: RW])) begin
            wb_wren_o[0] = 1'b0;
          end
          if (commit[0]) begin
            debug_wb_pc       = pc_q[DW-1:0];
            debug_wb_rf_wen   = TRACE_WEN_ALL;
            debug_wb_rf_wnum  = waddr_q[RW-1:0];
            debug_wb_rf_wdata = result[DW-1:0];
          end else if (commit[1]) begin
            debug_wb_pc       = pc_q[DW +: DW];
            debug_wb_rf_wen   = TRACE_WEN_ALL;
            debug_wb_rf_wnum  = waddr_q[RW +: RW];
            debug_wb_rf_wdata = result[DW +: DW];
          end
          if (commit[0] && commit[1]) begin
            wb_busy_o  = 1'b1;
            sh_pc_d    = pc_q[DW +: DW];
            sh_wnum_d  = waddr_q[RW +: RW];
            sh_wdata_d = result[DW +: DW];
            state_d    = S_SECOND;
          end
        end
        S_SECOND: begin
          debug_wb_pc       = sh_pc_q;
          debug_wb_rf_wen   = TRACE_WEN_ALL;
          debug_wb_rf_wnum  = sh_wnum_q;
          debug_wb_rf_wdata = sh_wdata_q;
          state_d           = S_RUN;
        end
        default: state_d = S_RUN;
      endcase
    end

    // FSM state and shadow trace record.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q    <= S_RUN;
        sh_pc_q    <= '0;
        sh_wnum_q  <= '0;
        sh_wdata_q <= '0;
      end else begin
        state_q    <= state_d;
        sh_pc_q    <= sh_pc_d;
        sh_wnum_q  <= sh_wnum_d;
        sh_wdata_q <= sh_wdata_d;
      end
    end
  end else begin : g_single
    // Single lane: no serialisation needed, trace follows lane 0 directly.
    always_comb begin
      wb_busy_o         = 1'b0;
      wb_wren_o         = wen_raw;
      debug_wb_pc       = pc_q[DW-1:0];
      debug_wb_rf_wen   = 4'h0;
      debug_wb_rf_wnum  = '0;
      debug_wb_rf_wdata = '0;
      if (commit[0]) begin
        debug_wb_rf_wen   = TRACE_WEN_ALL;
        debug_wb_rf_wnum  = waddr_q[RW-1:0];
        debug_wb_rf_wdata = result[DW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_wb_commit.sv
// Directed bench for wb_commit (2 lanes); trace records are scoreboarded.
module tb_wb_commit;
  import cpu_pkg::*;

  localparam int LANES = 2;
  localparam int DW    = 32;
  localparam int RW    = 5;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    wb_stall_i = 1'b0;
  logic                    wb_flush_i = 1'b0;
  logic [LANES-1:0]        in_valid_i;
  logic [LANES*DW-1:0]     in_pc_i;
  logic [LANES*MMOP_W-1:0] in_memop_i;
  logic [LANES-1:0]        in_wren_i;
  logic [LANES*RW-1:0]     in_waddr_i;
  logic [LANES*DW-1:0]     in_wdata_i;
  logic [LANES*2-1:0]      in_maddr_lo_i;
  logic [LANES*DW-1:0]     mem_rdata_i;
  logic                    wb_busy_o;
  logic [LANES-1:0]        wb_wren_o;
  logic [LANES*RW-1:0]     wb_waddr_o;
  logic [LANES*DW-1:0]     wb_wdata_o;
  logic [DW-1:0]           debug_wb_pc;
  logic [3:0]              debug_wb_rf_wen;
  logic [RW-1:0]           debug_wb_rf_wnum;
  logic [DW-1:0]           debug_wb_rf_wdata;

  wb_commit #(.LANES(LANES), .DW(DW), .RW(RW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .wb_stall_i        (wb_stall_i),
    .wb_flush_i        (wb_flush_i),
    .in_valid_i        (in_valid_i),
    .in_pc_i           (in_pc_i),
    .in_memop_i        (in_memop_i),
    .in_wren_i         (in_wren_i),
    .in_waddr_i        (in_waddr_i),
    .in_wdata_i        (in_wdata_i),
    .in_maddr_lo_i     (in_maddr_lo_i),
    .mem_rdata_i       (mem_rdata_i),
    .wb_busy_o         (wb_busy_o),
    .wb_wren_o         (wb_wren_o),
    .wb_waddr_o        (wb_waddr_o),
    .wb_wdata_o        (wb_wdata_o),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } trace_t;

  trace_t      sb_q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] m0 = '0;
  logic [31:0] m1 = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [4:0] wnum, input logic [31:0] wdata);
    trace_t t;
    t.pc = pc;
    t.wnum = wnum;
    t.wdata = wdata;
    sb_q.push_back(t);
  endtask

  task automatic clear_in();
    in_valid_i    = '0;
    in_pc_i       = '0;
    in_memop_i    = '0;
    in_wren_i     = '0;
    in_waddr_i    = '0;
    in_wdata_i    = '0;
    in_maddr_lo_i = '0;
  endtask

  task automatic set_lane(input int l, input logic v, input logic [31:0] pc, input mmop_e op,
                          input logic we, input logic [4:0] wa, input logic [31:0] wd,
                          input logic [1:0] lo);
    in_valid_i[l]                 = v;
    in_pc_i[l*DW +: DW]           = pc;
    in_memop_i[l*MMOP_W +: MMOP_W] = op;
    in_wren_i[l]                  = we;
    in_waddr_i[l*RW +: RW]        = wa;
    in_wdata_i[l*DW +: DW]        = wd;
    in_maddr_lo_i[l*2 +: 2]       = lo;
  endtask

  // Capture edge, then present read data for the held load, sample at +2.
  task automatic issue();
    @(posedge clk);
    #1;
    mem_rdata_i = {m1, m0};
    #1;
  endtask

  // Trace scoreboard: every committed trace record must match the queue head.
  always @(negedge clk) begin
    trace_t t;
    if (debug_wb_rf_wen !== 4'h0) begin
      chk("trace_expected", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        t = sb_q.pop_front();
        chk("trace_wen", debug_wb_rf_wen, 4'hF);
        chk("trace_pc", debug_wb_pc, t.pc);
        chk("trace_wnum", debug_wb_rf_wnum, t.wnum);
        chk("trace_wdata", debug_wb_rf_wdata, t.wdata);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_in();
    mem_rdata_i = '0;
    #2;
    chk("rst_wren", wb_wren_o, 2'b00);
    chk("rst_busy", wb_busy_o, 1'b0);
    chk("rst_dbg_wen", debug_wb_rf_wen, 4'h0);
    chk("rst_dbg_pc", debug_wb_pc, 32'h0);
    chk("rst_dbg_wnum", debug_wb_rf_wnum, 5'h0);
    chk("rst_dbg_wdata", debug_wb_rf_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // LB / LBU at offset 3
    set_lane(0, 1'b1, 32'h100, LB, 1'b1, 5'd2, 32'h0, 2'd3);
    m0 = 32'h80FF_1234; m1 = 32'h0;
    push(32'h100, 5'd2, 32'hFFFF_FF80);
    issue(); clear_in();
    chk("lb_wdata", wb_wdata_o[31:0], 32'hFFFF_FF80);
    chk("lb_wren", wb_wren_o, 2'b01);
    chk("lb_busy", wb_busy_o, 1'b0);

    set_lane(0, 1'b1, 32'h104, LBU, 1'b1, 5'd2, 32'h0, 2'd3);
    push(32'h104, 5'd2, 32'h0000_0080);
    issue(); clear_in();
    chk("lbu_wdata", wb_wdata_o[31:0], 32'h0000_0080);

    // LWL / LWR merges
    set_lane(0, 1'b1, 32'h108, LWL, 1'b1, 5'd6, 32'h1122_3344, 2'd1);
    m0 = 32'hAABB_CCDD;
    push(32'h108, 5'd6, 32'hCCDD_3344);
    issue(); clear_in();
    chk("lwl_wdata", wb_wdata_o[31:0], 32'hCCDD_3344);

    set_lane(0, 1'b1, 32'h10C, LWR, 1'b1, 5'd6, 32'h1122_3344, 2'd2);
    push(32'h10C, 5'd6, 32'h1122_AABB);
    issue(); clear_in();
    chk("lwr_wdata", wb_wdata_o[31:0], 32'h1122_AABB);

    // Lane 1 alone commits an LW
    set_lane(1, 1'b1, 32'h110, LW, 1'b1, 5'd7, 32'h0, 2'd0);
    m1 = 32'hDEAD_BEEF;
    push(32'h110, 5'd7, 32'hDEAD_BEEF);
    issue(); clear_in();
    chk("lw1_wren", wb_wren_o, 2'b10);
    chk("lw1_wdata", wb_wdata_o[63:32], 32'hDEAD_BEEF);
    chk("lw1_busy", wb_busy_o, 1'b0);

    // $0 write: traced, never written
    set_lane(0, 1'b1, 32'h114, MOP_NONE, 1'b1, 5'd0, 32'h55, 2'd0);
    push(32'h114, 5'd0, 32'h55);
    issue(); clear_in();
    chk("r0_wren", wb_wren_o, 2'b00);

    // Dual LH / LHU
    set_lane(0, 1'b1, 32'h200, LH,  1'b1, 5'd1, 32'h0, 2'd2);
    set_lane(1, 1'b1, 32'h204, LHU, 1'b1, 5'd2, 32'h0, 2'd0);
    m0 = 32'h8001_0000; m1 = 32'h1234_F00D;
    push(32'h200, 5'd1, 32'hFFFF_8001);
    push(32'h204, 5'd2, 32'h0000_F00D);
    issue(); clear_in();
    chk("lh_dual_wdata", wb_wdata_o, {32'h0000_F00D, 32'hFFFF_8001});
    chk("lh_dual_busy", wb_busy_o, 1'b1);
    chk("lh_dual_wren", wb_wren_o, 2'b11);
    @(posedge clk); #2;
    chk("lh_second_busy", wb_busy_o, 1'b0);
    chk("lh_second_wren", wb_wren_o, 2'b00);

    // Dual commit with next bundle waiting on the inputs
    set_lane(0, 1'b1, 32'hBFC0_0000, MOP_NONE, 1'b1, 5'd3, 32'd5, 2'd0);
    set_lane(1, 1'b1, 32'hBFC0_0004, MOP_NONE, 1'b1, 5'd4, 32'd6, 2'd0);
    push(32'hBFC0_0000, 5'd3, 32'd5);
    push(32'hBFC0_0004, 5'd4, 32'd6);
    push(32'hBFC0_0008, 5'd9, 32'd7);
    issue();
    clear_in();
    set_lane(0, 1'b1, 32'hBFC0_0008, MOP_NONE, 1'b1, 5'd9, 32'd7, 2'd0);
    chk("dual_c0_wren", wb_wren_o, 2'b11);
    chk("dual_c0_busy", wb_busy_o, 1'b1);
    chk("dual_c0_waddr", wb_waddr_o, {5'd4, 5'd3});
    chk("dual_c0_wdata", wb_wdata_o, {32'd6, 32'd5});
    @(posedge clk); #2;
    chk("dual_c1_busy", wb_busy_o, 1'b0);
    chk("dual_c1_wren", wb_wren_o, 2'b00);
    chk("dual_c1_held", wb_waddr_o[4:0], 5'd3);
    @(posedge clk); #2;
    chk("dual_c2_wren", wb_wren_o, 2'b01);
    chk("dual_c2_waddr", wb_waddr_o[4:0], 5'd9);
    chk("dual_c2_wdata", wb_wdata_o[31:0], 32'd7);
    clear_in();

    // Same destination: younger lane wins, both traced
    set_lane(0, 1'b1, 32'h400, MOP_NONE, 1'b1, 5'd8, 32'd1, 2'd0);
    set_lane(1, 1'b1, 32'h404, MOP_NONE, 1'b1, 5'd8, 32'd2, 2'd0);
    push(32'h400, 5'd8, 32'd1);
    push(32'h404, 5'd8, 32'd2);
    issue(); clear_in();
    chk("same_wren", wb_wren_o, 2'b10);
    chk("same_busy", wb_busy_o, 1'b1);
    @(posedge clk); #2;
    chk("same_c1_wren", wb_wren_o, 2'b00);
    @(posedge clk); #2;
    chk("same_idle_wen", debug_wb_rf_wen, 4'h0);

    // Stall holds the (idle) stage; bundle enters once released
    wb_stall_i = 1'b1;
    set_lane(0, 1'b1, 32'h300, MOP_NONE, 1'b1, 5'd5, 32'h77, 2'd0);
    @(posedge clk); #2;
    chk("stall_wren", wb_wren_o, 2'b00);
    wb_stall_i = 1'b0;
    push(32'h300, 5'd5, 32'h77);
    @(posedge clk); #2;
    chk("unstall_wren", wb_wren_o, 2'b01);
    chk("unstall_wdata", wb_wdata_o[31:0], 32'h77);
    clear_in();

    // Flush during the busy cycle
    set_lane(0, 1'b1, 32'h500, MOP_NONE, 1'b1, 5'd10, 32'hA, 2'd0);
    set_lane(1, 1'b1, 32'h504, MOP_NONE, 1'b1, 5'd11, 32'hB, 2'd0);
    push(32'h500, 5'd10, 32'hA);
    push(32'h504, 5'd11, 32'hB);
    issue(); clear_in();
    wb_flush_i = 1'b1;
    chk("flush_c0_wren", wb_wren_o, 2'b11);
    chk("flush_c0_busy", wb_busy_o, 1'b1);
    @(posedge clk); #1;
    wb_flush_i = 1'b0;
    #1;
    chk("flush_c1_wren", wb_wren_o, 2'b00);
    chk("flush_c1_busy", wb_busy_o, 1'b0);
    @(posedge clk); #2;
    chk("flush_c2_wren", wb_wren_o, 2'b00);
    chk("flush_c2_wen", debug_wb_rf_wen, 4'h0);

    // Reset in S_SECOND drops the pending lane-1 trace
    set_lane(0, 1'b1, 32'h600, MOP_NONE, 1'b1, 5'd12, 32'hC, 2'd0);
    set_lane(1, 1'b1, 32'h604, MOP_NONE, 1'b1, 5'd13, 32'hD, 2'd0);
    push(32'h600, 5'd12, 32'hC);
    issue(); clear_in();
    chk("rstmid_busy", wb_busy_o, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_wen", debug_wb_rf_wen, 4'h0);
    chk("rstmid_pc", debug_wb_pc, 32'h0);
    chk("rstmid_wnum", debug_wb_rf_wnum, 5'h0);
    chk("rstmid_wdata", debug_wb_rf_wdata, 32'h0);
    chk("rstmid_wren", wb_wren_o, 2'b00);
    chk("rstmid_busy0", wb_busy_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #2;
    chk("rstrel_wen", debug_wb_rf_wen, 4'h0);
    chk("rstrel_busy", wb_busy_o, 1'b0);

    repeat (2) @(posedge clk);
    #2;
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_commit.md
# wb_commit

Parametrised writeback/commit stage for the MIPS pipeline. Owns the MEM→WB pipeline register for up to `LANES` issue lanes and performs load-data extraction and sign/zero extension, including `LWL`/`LWR` merges. Drives one regfile write port per lane and serialises dual commits onto the single debug trace port, back-pressuring upstream for one cycle when two lanes write in the same cycle.

## Interface

- `LANES`, default 2: issue lanes; legal values are 1 and 2.
- `DW`, default 32: data and PC width.
- `RW`, default 5: register index width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wb_stall_i`  in  1  hold the stage register.
- `wb_flush_i`  in  1  invalidate the stage register at the next edge.
- `in_valid_i`  in  LANES  per-lane instruction valid from MEM.
- `in_pc_i`  in  LANES*DW  per-lane PC.
- `in_memop_i`  in  LANES*MMOP_W  per-lane memory op (package enum).
- `in_wren_i`  in  LANES  per-lane register write enable.
- `in_waddr_i`  in  LANES*RW  per-lane destination register.
- `in_wdata_i`  in  LANES*DW  per-lane ALU result; for `LWL`/`LWR` this is the old rt value.
- `in_maddr_lo_i`  in  LANES*2  per-lane byte offset of the memory address.
- `mem_rdata_i`  in  LANES*DW  data-RAM read data; arrives combinationally in the cycle the stage register holds the load.
- `wb_busy_o`  out  1  upstream must not advance.
- `wb_wren_o`  out  LANES  regfile write enables.
- `wb_waddr_o`  out  LANES*RW  regfile write addresses.
- `wb_wdata_o`  out  LANES*DW  final write data; also the forwarding source.
- `debug_wb_pc`  out  DW  trace PC.
- `debug_wb_rf_wen`  out  4  trace write enables.
- `debug_wb_rf_wnum`  out  RW  trace register number.
- `debug_wb_rf_wdata`  out  DW  trace write data.

## Operation

**Stage register**
- Per-lane fields: `valid`, `pc`, `memop`, `wren`, `waddr`, `wdata`, `lo`.
- Priority, highest first: reset → flush → hold → load.
- Flush clears all `valid` bits.
- Hold applies when `wb_stall_i` or `wb_busy_o` is high.
- Otherwise the register loads all `in_*` inputs.

**Load extraction**, per lane, combinational. `b` is the byte at offset `lo` and `h` is the halfword at `lo[1]`, little-endian.
- `LB` → sign-extended `b`; `LBU` → zero-extended `b`.
- `LH` → sign-extended `h`; `LHU` → zero-extended `h`.
- `LW` → `mem_rdata` unchanged.
- `LWL`: `lo`=0 → `{m[7:0], r[23:0]}`; 1 → `{m[15:0], r[15:0]}`; 2 → `{m[23:0], r[7:0]}`; 3 → `m`. Here `m` is `mem_rdata` and `r` is `wdata`.
- `LWR`: `lo`=0 → `m`; 1 → `{r[31:24], m[31:8]}`; 2 → `{r[31:16], m[31:16]}`; 3 → `{r[31:8], m[31:24]}`.
- Any other memop → `wdata` unchanged.
- Misaligned `LH`/`LW` never reach this stage; behaviour for them is don't-care.

**Regfile write enable**
- `wb_wren_o[i]` = `valid[i] & wren[i] & (waddr[i]≠0) & (state==S_RUN)`.
- If both lanes target the same `waddr`, lane 0's enable is forced to 0 so the younger lane wins.

**Trace FSM**, states `S_RUN` and `S_SECOND`.
- **S_RUN**: the debug port shows the lowest committing lane. Committing means `valid & wren`, with `$0` included so the trace matches the golden model.
  - If both lanes are committing: `wb_busy_o`=1, the lane-1 trace fields are latched into a shadow register, and the next state is `S_SECOND`.
  - If no lane is committing: `debug_wb_rf_wen`=0 and `debug_wb_pc` = lane-0 pc.
- **S_SECOND**: the debug port shows the shadow register, regfile enables are 0, `wb_busy_o`=0, and the next state is `S_RUN`.
- `debug_wb_rf_wen` is `{4{commit}}`.
- `LANES`=1 removes `S_SECOND` and the shadow register; `wb_busy_o` ties to 0.

**Boundary conditions**
- Flush in `S_RUN` while busy: the regfile writes of that cycle still occur, the FSM still enters `S_SECOND` so lane 1's trace is emitted, and `valid` clears at the same edge.
- Stall in `S_SECOND`: the FSM still returns to `S_RUN`. The shadow trace is emitted exactly once.
- Asynchronous reset mid-`S_SECOND`: the pending trace is dropped.

## Timing

- Inputs are captured at edge N; regfile and trace outputs are combinational from the stage register during cycle N to N+1. Regfile latency is one cycle.
- `wb_busy_o` is combinational from the stage register and state. It is high for exactly one cycle per dual commit; the lane-1 trace appears one cycle after the lane-0 trace.
- `mem_rdata_i` must be stable before the edge that ends the cycle.
- Reset values:
  - all `valid` = 0; state = `S_RUN`; shadow register = 0.
  - `wb_wren_o` = 0, `wb_busy_o` = 0.
  - `debug_wb_rf_wen` = 0, `debug_wb_pc` = 0, `debug_wb_rf_wnum` = 0, `debug_wb_rf_wdata` = 0.

## Structure

- Package `cpu_pkg`: `MMOP_W`, the memop enum (`MOP_NONE`, `LB`, `LBU`, `LH`, `LHU`, `LW`, `LWL`, `LWR`, plus store codes), and the state enum.
- Sub-module `wb_load_align`: purely combinational, one instance per lane via generate. Ports: `memop`, `lo`, `mem_rdata`, `wdata` → `result`.

## Test plan

- Single lane `LB`, `lo`=3, `mem_rdata`=0x80FF_1234 → `wb_wdata_o`=0xFFFF_FF80; `LBU` at the same offset → 0x0000_0080.
- `LWL`, `lo`=1, `m`=0xAABB_CCDD, `r`=0x1122_3344 → 0xCCDD_3344; `LWR`, `lo`=2, same `m` and `r` → 0x1122_AABB.
- Dual commit: lane 0 (pc 0xBFC0_0000, `$3`, 5) and lane 1 (pc 0xBFC0_0004, `$4`, 6) → both enables high in cycle 0 with busy=1; trace shows `$3`/5, then `$4`/6 in cycle 1; the next input bundle is captured only after cycle 1.
- Same-`waddr` dual write to `$8` (lane 0 = 1, lane 1 = 2) → only lane 1 writes to the regfile; two trace lines are still emitted, value 1 then value 2.
- Flush asserted in the busy cycle → the second trace is still emitted, then `valid`=0; no write enables follow.
- Reset asserted during `S_SECOND` → all outputs go to 0 immediately and no lane-1 trace appears after release.
